// File: rtl/match_window_counter.sv
// Counts sampled detector matches over a programmed window of N cycles, reports the window
// count over a valid/ready port, and keeps a free-running saturating total of all matches.
module match_window_counter #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned WIN_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             det_out_i,
    input  logic             start_i,
    input  logic [WIN_W-1:0] win_len_i,
    input  logic             clr_total_i,
    output logic             match_q_o,
    output logic             busy_o,
    output logic             rpt_valid_o,
    input  logic             rpt_ready_i,
    output logic [CNT_W-1:0] rpt_data_o,
    output logic             rpt_sat_o,
    output logic [CNT_W-1:0] total_cnt_o
);

    typedef enum logic [1:0] {StIdle, StCount, StReport} state_e;

    state_e             state_q;
    logic [WIN_W-1:0]   win_cnt_q;
    logic [CNT_W-1:0]   win_acc_q, win_acc_d;
    logic [CNT_W-1:0]   total_q, total_d;
    logic [CNT_W-1:0]   rpt_data_q;
    logic               rpt_sat_q;
    logic               rpt_valid_q;
    logic               busy_q;
    logic               det_q;

    // Both counters hold at all-ones; the window count never decreases, so saturation sticks.
    always_comb begin
        win_acc_d = win_acc_q;
        if (det_out_i && (win_acc_q != '1)) begin
            win_acc_d = win_acc_q + CNT_W'(1);
        end
        total_d = total_q;
        if (clr_total_i) begin
            total_d = '0;
        end else if (det_out_i && (total_q != '1)) begin
            total_d = total_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            win_cnt_q   <= '0;
            win_acc_q   <= '0;
            total_q     <= '0;
            rpt_data_q  <= '0;
            rpt_sat_q   <= 1'b0;
            rpt_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            det_q       <= 1'b0;
        end else begin
            det_q   <= det_out_i;
            total_q <= total_d;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        win_acc_q <= '0;
                        busy_q    <= 1'b1;
                        if (win_len_i == '0) begin
                            state_q     <= StReport;
                            rpt_valid_q <= 1'b1;
                            rpt_data_q  <= '0;
                            rpt_sat_q   <= 1'b0;
                        end else begin
                            state_q   <= StCount;
                            win_cnt_q <= win_len_i;
                        end
                    end
                end
                StCount: begin
                    win_acc_q <= win_acc_d;
                    win_cnt_q <= win_cnt_q - WIN_W'(1);
                    // The last window edge's sample goes straight into the report.
                    if (win_cnt_q == WIN_W'(1)) begin
                        state_q     <= StReport;
                        rpt_valid_q <= 1'b1;
                        rpt_data_q  <= win_acc_d;
                        rpt_sat_q   <= (win_acc_d == '1);
                    end
                end
                StReport: begin
                    if (rpt_ready_i) begin
                        state_q     <= StIdle;
                        rpt_valid_q <= 1'b0;
                        rpt_data_q  <= '0;
                        rpt_sat_q   <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign match_q_o   = det_q;
    assign busy_o      = busy_q;
    assign rpt_valid_o = rpt_valid_q;
    assign rpt_data_o  = rpt_data_q;
    assign rpt_sat_o   = rpt_sat_q;
    assign total_cnt_o = total_q;

endmodule

// File: tb/tb_match_window_counter.sv
// Directed bench for match_window_counter: a vector table for the main window and
// backpressure flow, plus hand-written sequences for boundaries, saturation and reset.
module tb_match_window_counter;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned WIN_W = 8;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             det_out_i = 1'b0;
    logic             start_i = 1'b0;
    logic [WIN_W-1:0] win_len_i = '0;
    logic             clr_total_i = 1'b0;
    logic             rpt_ready_i = 1'b0;
    logic             match_q_o;
    logic             busy_o;
    logic             rpt_valid_o;
    logic [CNT_W-1:0] rpt_data_o;
    logic             rpt_sat_o;
    logic [CNT_W-1:0] total_cnt_o;

    int checks = 0;
    int errors = 0;

    match_window_counter #(
        .CNT_W(CNT_W),
        .WIN_W(WIN_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .det_out_i   (det_out_i),
        .start_i     (start_i),
        .win_len_i   (win_len_i),
        .clr_total_i (clr_total_i),
        .match_q_o   (match_q_o),
        .busy_o      (busy_o),
        .rpt_valid_o (rpt_valid_o),
        .rpt_ready_i (rpt_ready_i),
        .rpt_data_o  (rpt_data_o),
        .rpt_sat_o   (rpt_sat_o),
        .total_cnt_o (total_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       start;
        logic [7:0] len;
        logic       det;
        logic       ready;
        logic       clr;
        logic       e_valid;
        logic [3:0] e_data;
        logic       e_sat;
        logic [3:0] e_total;
        logic       e_busy;
        logic       e_match;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic st, logic [7:0] len, logic det, logic rdy, logic clr,
                                logic ev, logic [3:0] ed, logic es, logic [3:0] et,
                                logic eb, logic em);
        vec_t v;
        v.start = st;  v.len = len;  v.det = det;  v.ready = rdy;  v.clr = clr;
        v.e_valid = ev;  v.e_data = ed;  v.e_sat = es;  v.e_total = et;
        v.e_busy = eb;  v.e_match = em;
        return v;
    endfunction

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic st, input logic [7:0] len, input logic det,
                         input logic rdy, input logic clr);
        start_i = st;  win_len_i = len;  det_out_i = det;  rpt_ready_i = rdy;
        clr_total_i = clr;
    endtask

    task automatic do_reset();
        drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        rst_ni = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
        step();
    endtask

    task automatic chk_rpt(input string tag, input int unsigned v, input int unsigned d,
                           input int unsigned s, input int unsigned t, input int unsigned b);
        chk({tag, " valid"}, rpt_valid_o, v);
        chk({tag, " data"}, rpt_data_o, d);
        chk({tag, " sat"}, rpt_sat_o, s);
        chk({tag, " total"}, total_cnt_o, t);
        chk({tag, " busy"}, busy_o, b);
    endtask

    initial begin
        logic seen_valid;

        // Reset held with det_out toggling: everything must stay at zero.
        rst_ni = 1'b0;
        for (int i = 0; i < 4; i++) begin
            det_out_i = i[0];
            start_i = 1'b1;
            win_len_i = 8'd3;
            step();
        end
        chk_rpt("reset", 0, 0, 0, 0, 0);
        chk("reset match", match_q_o, 0);
        drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        rst_ni = 1'b1;
        step();
        chk_rpt("post_reset", 0, 0, 0, 0, 0);

        // N=8 window with matches on window edges 2,3,4,7, then 5 cycles of backpressure
        // with det_out high (a start inside REPORT is ignored), then handshake.
        vecs.push_back(mk(1, 8, 0, 0, 0,  0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,  0, 0, 0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0,  0, 0, 0, 2, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0,  0, 0, 0, 3, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 3, 1, 0));
        vecs.push_back(mk(1, 2, 0, 0, 0,  0, 0, 0, 3, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,  0, 0, 0, 4, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 4, 0, 4, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,  1, 4, 0, 5, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0,  1, 4, 0, 6, 1, 1));
        vecs.push_back(mk(1, 2, 1, 0, 0,  1, 4, 0, 7, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0,  1, 4, 0, 8, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0,  1, 4, 0, 9, 1, 1));
        vecs.push_back(mk(1, 3, 0, 1, 0,  0, 0, 0, 9, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 9, 0, 0));
        foreach (vecs[i]) begin
            drive(vecs[i].start, vecs[i].len, vecs[i].det, vecs[i].ready, vecs[i].clr);
            step();
            chk_rpt($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_data, vecs[i].e_sat,
                    vecs[i].e_total, vecs[i].e_busy);
            chk($sformatf("vec%0d match", i), match_q_o, vecs[i].e_match);
        end

        // N=0 goes to REPORT after one edge with an empty count.
        do_reset();
        drive(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk_rpt("n0 report", 1, 0, 0, 0, 1);
        drive(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        step();
        chk_rpt("n0 idle", 0, 0, 0, 0, 0);

        // N=1: match on the start edge ignored, on E1 counted, on E2 not counted.
        drive(1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
        step();
        chk_rpt("n1 e0", 0, 0, 0, 1, 1);
        drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        step();
        chk_rpt("n1 e1", 1, 1, 0, 2, 1);
        step();
        chk_rpt("n1 e2", 1, 1, 0, 3, 1);
        drive(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        step();
        chk_rpt("n1 done", 0, 0, 0, 3, 0);

        // Saturation: N=20 with det_out high throughout.
        do_reset();
        drive(1'b1, 8'd20, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 20; i++) step();
        chk_rpt("sat e19", 0, 0, 0, 15, 1);
        step();
        chk_rpt("sat e20", 1, 15, 1, 15, 1);
        drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        step();
        chk_rpt("sat clr", 1, 15, 1, 0, 1);
        drive(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        step();
        chk_rpt("sat done", 0, 0, 0, 0, 0);

        // Glitch between edges is not sampled; reset at window cycle 3 aborts at once.
        do_reset();
        drive(1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        step();
        #2 det_out_i = 1'b1;
        #1 det_out_i = 1'b0;
        step();
        chk("glitch match", match_q_o, 0);
        chk("glitch total", total_cnt_o, 0);
        det_out_i = 1'b1;
        step();
        chk_rpt("win c3", 0, 0, 0, 1, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk_rpt("abort", 0, 0, 0, 0, 0);
        chk("abort match", match_q_o, 0);
        step();
        #2 rst_ni = 1'b1;
        det_out_i = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (rpt_valid_o) seen_valid = 1'b1;
        end
        chk("abort no valid", seen_valid, 0);
        chk("abort busy", busy_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
